// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/result bundle between the execute stage and the iterative
//   multiply/divide unit.
//
//   Request  (master -> slave): start, op[1:0], a[N-1:0], b[N-1:0]
//   Response (slave -> master): busy, done, hi[N-1:0], lo[N-1:0], divz, ill
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         divz;
    logic         ill;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, divz, ill
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, divz, ill
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit for the MIPS execute stage.
//   mult/multu produce an N x N -> 2N product (hi:lo); div/divu produce the
//   quotient in lo and the remainder in hi. One bit is processed per cycle on
//   operand magnitudes; signs are applied in a single fix-up cycle.
//
//   Ports:
//     clk     rising-edge clock
//     rst     synchronous active-high reset
//     mdu_if  slave side of muldiv_unit_if
//               start/op/a/b  request, sampled when the unit is not busy
//               busy          RUN or FIX in progress
//               done          one-cycle completion pulse
//               hi/lo         result registers, held until next completion
//               divz          last completed op was a divide by zero
//               ill           last completed op was unsupported
//
//   Build option: define MULDIV_DIV_EN to include the divide datapath.
//   Without it, div/divu complete in two cycles with ill=1, hi=lo=0.
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave mdu_if
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           divz_q, divz_d, ill_q, ill_d;

    // Datapath state (no reset needed: always loaded on start)
    logic           div_q, div_d;
    logic           neg_lo_q, neg_lo_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mcand_q, mcand_d;
`ifdef MULDIV_DIV_EN
    logic           neg_hi_q, neg_hi_d;
    logic           zdiv_q, zdiv_d;
`endif

    function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic is_signed);
        return (is_signed && x[N-1]) ? -x : x;
    endfunction

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    logic           sgn;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     psum;
    logic [2*N-1:0] mult_step;

    // op[0]=0 selects the signed variants
    assign sgn   = ~mdu_if.op[0];
    assign a_mag = mag(mdu_if.a, sgn);
    assign b_mag = mag(mdu_if.b, sgn);

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign psum      = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};
    assign mult_step = acc_q[0] ? {psum, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};

`ifdef MULDIV_DIV_EN
    logic [N:0]     rem_sh, trial;
    logic [2*N-1:0] div_step;

    // Restoring division: acc = {remainder, dividend bits -> quotient bits}.
    // The remainder stays below the divisor, so the shifted remainder is
    // below 2*divisor and trial[N] alone signals a borrow.
    assign rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    assign trial    = rem_sh - {1'b0, mcand_q};
    assign div_step = trial[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                               : {trial[N-1:0],  acc_q[N-2:0], 1'b1};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        divz_d   = divz_q;
        ill_d    = ill_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
`ifdef MULDIV_DIV_EN
        neg_hi_d = neg_hi_q;
        zdiv_d   = zdiv_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (mdu_if.start) begin
                    div_d    = mdu_if.op[1];
                    cnt_d    = CW'(N);
                    neg_lo_d = sgn & (mdu_if.a[N-1] ^ mdu_if.b[N-1]);
                    if (mdu_if.op[1]) begin
                        acc_d   = {{N{1'b0}}, a_mag};
                        mcand_d = b_mag;
                    end else begin
                        acc_d   = {{N{1'b0}}, b_mag};
                        mcand_d = a_mag;
                    end
`ifdef MULDIV_DIV_EN
                    neg_hi_d = sgn & mdu_if.a[N-1];
                    zdiv_d   = mdu_if.op[1] & (mdu_if.b == '0);
                    state_d  = RUN;
`else
                    // Unsupported divide skips straight to the fix-up cycle
                    state_d  = mdu_if.op[1] ? FIX : RUN;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d = div_q ? div_step : mult_step;
`else
                acc_d = mult_step;
`endif
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                state_d = DONE;
                ill_d   = 1'b0;
                divz_d  = 1'b0;
                if (div_q) begin
`ifdef MULDIV_DIV_EN
                    lo_d   = zdiv_q ? '1 : neg_n(acc_q[N-1:0], neg_lo_q);
                    hi_d   = neg_n(acc_q[2*N-1:N], neg_hi_q);
                    divz_d = zdiv_q;
`else
                    lo_d   = '0;
                    hi_d   = '0;
                    ill_d  = 1'b1;
`endif
                end else begin
                    {hi_d, lo_d} = neg_2n(acc_q, neg_lo_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            divz_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            divz_q  <= divz_d;
            ill_q   <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        div_q    <= div_d;
        neg_lo_q <= neg_lo_d;
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
`ifdef MULDIV_DIV_EN
        neg_hi_q <= neg_hi_d;
        zdiv_q   <= zdiv_d;
`endif
    end

    assign mdu_if.busy = (state_q == RUN) || (state_q == FIX);
    assign mdu_if.done = (state_q == DONE);
    assign mdu_if.hi   = hi_q;
    assign mdu_if.lo   = lo_q;
    assign mdu_if.divz = divz_q;
    assign mdu_if.ill  = ill_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit (N=32). Divide vectors are
//   selected by MULDIV_DIV_EN to match the build under test.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam int N = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_DIV_EN
    localparam int DIV_LAT = N + 2;
`else
    localparam int DIV_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.N(N)) mdu_if ();

    muldiv_unit #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .mdu_if (mdu_if)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divz;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic divz, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        v.divz = divz; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Caller is at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_if.op    = op;
        mdu_if.a     = a;
        mdu_if.b     = b;
        mdu_if.start = 1'b1;
        @(posedge clk);
        #1 mdu_if.start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; returns at that negedge.
    task automatic wait_done(input string name, output int cyc, output int busyc);
        cyc   = 0;
        busyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mdu_if.busy === 1'b1) busyc++;
        end while (mdu_if.done !== 1'b1 && cyc < 100);
        if (mdu_if.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no done within %0d cycles", name, cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bc, ndone, nbusy;

        add(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, N + 2);
        add(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, N + 2);
        add(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, N + 2);
        add(MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 1'b0, N + 2);
        add(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, N + 2);
`ifdef MULDIV_DIV_EN
        add(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT);
        add(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, DIV_LAT);
        add(DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0, DIV_LAT);
        add(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, DIV_LAT);
        add(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT);
        add(DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0, DIV_LAT);
        add(DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0, DIV_LAT);
`else
        add(DIV,   32'd10,       32'd3,        32'd0,        32'd0,        1'b0, 1'b1, DIV_LAT);
        add(MULT,  32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 1'b0, N + 2);
        add(DIVU,  32'd100,      32'd0,        32'd0,        32'd0,        1'b0, 1'b1, DIV_LAT);
`endif
        add(MULT,  32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 1'b0, N + 2);

        // Reset state
        rst          = 1'b1;
        mdu_if.start = 1'b0;
        mdu_if.op    = 2'b00;
        mdu_if.a     = '0;
        mdu_if.b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.busy", 64'(mdu_if.busy), 64'd0);
        chk("rst.done", 64'(mdu_if.done), 64'd0);
        chk("rst.hi",   64'(mdu_if.hi),   64'd0);
        chk("rst.lo",   64'(mdu_if.lo),   64'd0);
        chk("rst.divz", 64'(mdu_if.divz), 64'd0);
        chk("rst.ill",  64'(mdu_if.ill),  64'd0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("v%0d", i), c, bc);
            chk($sformatf("v%0d.lat", i),  64'(c),  64'(vecs[i].lat));
            chk($sformatf("v%0d.busy", i), 64'(bc), 64'(vecs[i].lat - 1));
            chk($sformatf("v%0d.hi", i),   64'(mdu_if.hi),   64'(vecs[i].hi));
            chk($sformatf("v%0d.lo", i),   64'(mdu_if.lo),   64'(vecs[i].lo));
            chk($sformatf("v%0d.divz", i), 64'(mdu_if.divz), 64'(vecs[i].divz));
            chk($sformatf("v%0d.ill", i),  64'(mdu_if.ill),  64'(vecs[i].ill));
            @(negedge clk);
            chk($sformatf("v%0d.done_pulse", i), 64'(mdu_if.done), 64'd0);
        end

        // Back-to-back start in the DONE cycle; results hold while running
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("b2b.first", c, bc);
        chk("b2b.first_hi", 64'(mdu_if.hi), 64'hFFFFFFFE);
        issue(MULT, 32'd6, 32'd7);
        @(negedge clk);
        chk("b2b.busy_next", 64'(mdu_if.busy), 64'd1);
        chk("b2b.done_low",  64'(mdu_if.done), 64'd0);
        chk("b2b.hold_hi",   64'(mdu_if.hi),   64'hFFFFFFFE);
        chk("b2b.hold_lo",   64'(mdu_if.lo),   64'h00000001);
        wait_done("b2b.second", c, bc);
        chk("b2b.lat", 64'(c + 1), 64'(N + 2));
        chk("b2b.hi",  64'(mdu_if.hi), 64'd0);
        chk("b2b.lo",  64'(mdu_if.lo), 64'd42);
        @(negedge clk);

        // start pulsed while busy is ignored
        issue(MULT, 32'hFFFFFFFD, 32'd7);
        repeat (4) @(negedge clk);
        issue(DIVU, 32'd1, 32'd1);
        wait_done("ign", c, bc);
        chk("ign.lat", 64'(c + 4), 64'(N + 2));
        chk("ign.hi",  64'(mdu_if.hi),  64'hFFFFFFFF);
        chk("ign.lo",  64'(mdu_if.lo),  64'hFFFFFFEB);
        chk("ign.ill", 64'(mdu_if.ill), 64'd0);
        @(negedge clk);

        // Reset mid-operation aborts with no done
        issue(MULT, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort.busy", 64'(mdu_if.busy), 64'd0);
        chk("abort.done", 64'(mdu_if.done), 64'd0);
        chk("abort.hi",   64'(mdu_if.hi),   64'd0);
        chk("abort.lo",   64'(mdu_if.lo),   64'd0);
        chk("abort.divz", 64'(mdu_if.divz), 64'd0);
        chk("abort.ill",  64'(mdu_if.ill),  64'd0);
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'd0);

        // rst and start together: request dropped
        mdu_if.op    = MULT;
        mdu_if.a     = 32'd3;
        mdu_if.b     = 32'd3;
        mdu_if.start = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        mdu_if.start = 1'b0;
        ndone = 0;
        nbusy = 0;
        repeat (50) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) ndone++;
            if (mdu_if.busy === 1'b1) nbusy++;
        end
        chk("rststart.no_busy", 64'(nbusy), 64'd0);
        chk("rststart.no_done", 64'(ndone), 64'd0);
        chk("rststart.lo",      64'(mdu_if.lo), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the MIPS execute stage, the sequential companion to the combinational add/subtract unit. It computes N×N→2N signed/unsigned products and N/N signed/unsigned quotient/remainder with one radix-2 step per cycle. Results go to HI/LO registers that hold their value until the next completion. A start/busy/done handshake lets the pipeline stall on `mfhi`/`mflo` hazards.

## Interface
- `N`, default 32: operand width, even, ≥ 4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; accepted only when `busy`=0.
- `op` in 2: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`; sampled with `start`.
- `a` in N: multiplicand / dividend; sampled with `start`.
- `b` in N: multiplier / divisor; sampled with `start`.
- `busy` out 1: operation in flight (states RUN, FIX).
- `done` out 1: one-cycle pulse; `hi`/`lo`/`divz`/`ill` valid and updated this cycle.
- `hi` out N: product high half / remainder.
- `lo` out N: product low half / quotient.
- `divz` out 1: last completed operation was a divide by zero.
- `ill` out 1: last completed operation was unsupported (see Configuration).

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE → RUN on `start`. Capture `op`, and take |a| and |b| for signed ops; raw values for unsigned.
  - Record the result sign (mult: a^b sign; div: quotient a^b, remainder a sign). Load the counter with N.
  - Other transitions:
    - DONE → IDLE when `start`=0.
    - RUN → FIX when the counter reaches 0 after the Nth step.
    - FIX → DONE unconditionally.
- RUN, multiply: shift-add on magnitudes. One multiplier bit per cycle, 2N-bit accumulator, N+1-bit partial-sum adder.
- RUN, divide: restoring division on magnitudes. One quotient bit per cycle, N+1-bit trial subtract.
- FIX:
  - Apply two's-complement negation per the recorded signs.
  - Signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
  - Write `hi`/`lo`/`divz`/`ill` at the end of FIX so they are visible in DONE.
- Divide by zero (`b`=0, div/divu): `lo`=all ones, `hi`=`a` unmodified, `divz`=1. Still takes the full latency.
- Signed overflow (`a`=−2^(N−1), `b`=−1, div): `lo`=−2^(N−1), `hi`=0, `divz`=0. No flag is raised.
- All arithmetic is modulo 2^N per half. There is no overflow output.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, `divz`=0, `ill`=0, counter 0.
- Latency, `start` sampled at edge k:
  - `busy`=1 from cycle k+1 through k+N+1.
  - `done`=1 in cycle k+N+2 only.
  - `hi`/`lo` change only at that edge.
- `start` while `busy`=1: ignored, no queuing, in-flight operation unaffected.
- `start` in the DONE cycle: accepted (back-to-back). `done` lasts one cycle and `busy` rises next cycle.
- `hi`/`lo`/`divz`/`ill` hold between completions, including while a new operation runs.
- `rst` mid-operation: abort, all outputs to reset values next cycle, no `done` pulse.
- `rst` and `start` in the same cycle: `rst` wins; the request is dropped.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: full unit as above. `ill` is always 0.
- Undefined: divide datapath is compiled out (no trial subtractor, no remainder register). Ops 10/11 go IDLE → DONE without RUN:
  - `done` pulses 2 cycles after the start edge, with `busy`=1 for the intervening cycle.
  - `ill`=1, `hi`=`lo`=0, `divz`=0.
  - Multiply behaviour and latency are unchanged.

## Test plan
- N=32, `mult` a=0xFFFFFFFD (−3), b=7: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` exactly 34 cycles after the start edge, `busy` high for 33 cycles.
- `multu` a=b=0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001. A back-to-back `start` in the DONE cycle is accepted.
- `div` a=0xFFFFFFF9 (−7), b=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then `div` a=0x80000000, b=0xFFFFFFFF: `lo`=0x80000000, `hi`=0, `divz`=0.
- `divu` a=100, b=0: `divz`=1, `hi`=0x00000064, `lo`=0xFFFFFFFF, done at cycle 34. A following `divu` 100/7 gives `lo`=14, `hi`=2, `divz`=0.
- `start` pulsed at cycle 5 of a running op: ignored, original result correct. `rst` at cycle 10 of an op: no `done`, all outputs 0 next cycle.
- `MULDIV_DIV_EN` undefined, `div` 10/3: `ill`=1, `hi`=`lo`=0, `done` 2 cycles after start. Then `mult` 6×7 gives `lo`=42, `ill`=0.
